// File: rtl/plcp_pkg.sv
// Shared PLCP definitions: receiver state encoding, field geometry and SIGNAL checks.
package plcp_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SIGNAL,
    SERVICE,
    DATA
  } plcp_state_t;

  localparam int PREAMBLE_BITS_DEF = 96;
  localparam int SERVICE_BITS_DEF  = 16;
  localparam int SIGNAL_BITS       = 24;

  // Offsets count received bit order; bit 0 lands in the MSB of the shift word.
  localparam int RATE_OFS   = 0;
  localparam int RATE_W     = 4;
  localparam int RSVD_OFS   = 4;
  localparam int LENGTH_OFS = 5;
  localparam int LENGTH_W   = 12;
  localparam int PARITY_OFS = 17;
  localparam int TAIL_OFS   = 18;
  localparam int TAIL_W     = 6;

  localparam int LFSR_W = 7;

  typedef logic [SIGNAL_BITS-1:0] signal_word_t;

  function automatic logic signal_check(input signal_word_t w);
    return !w[SIGNAL_BITS-1-RSVD_OFS]
        && !(^w[SIGNAL_BITS-1 -: PARITY_OFS+1])
        && !(|w[SIGNAL_BITS-1-TAIL_OFS -: TAIL_W]);
  endfunction

  function automatic logic [RATE_W-1:0] signal_rate(input signal_word_t w);
    return w[SIGNAL_BITS-1-RATE_OFS -: RATE_W];
  endfunction

  function automatic logic [LENGTH_W-1:0] signal_length(input signal_word_t w);
    return w[SIGNAL_BITS-1-LENGTH_OFS -: LENGTH_W];
  endfunction

endpackage

// File: rtl/plcp_receiver_descrambler.sv
// x^7+x^4+1 additive descrambler; only built when DESCRAMBLER_EN is defined.
`ifdef DESCRAMBLER_EN
module plcp_receiver_descrambler
  import plcp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic raw,
  output logic plain
);

  logic [LFSR_W-1:0] lfsr;
  logic              fb;

  assign fb    = lfsr[6] ^ lfsr[3];
  assign plain = raw ^ fb;

  // Loading raw scrambled-zero bits reproduces the transmitter's LFSR state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= {lfsr[LFSR_W-2:0], raw};
    end else if (step) begin
      lfsr <= {lfsr[LFSR_W-2:0], fb};
    end
  end

endmodule
`endif

// File: rtl/plcp_receiver.sv
// Bit-serial 802.11a PLCP receiver: preamble hunt, SIGNAL check, SERVICE skip, payload delivery.
// Optional payload descrambling is enabled by defining DESCRAMBLER_EN.
module plcp_receiver
  import plcp_pkg::*;
#(
  parameter int PREAMBLE_BITS = PREAMBLE_BITS_DEF,
  parameter int SERVICE_BITS  = SERVICE_BITS_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Input,
  output logic        Output,
  output logic        OutputValid,
  output logic [3:0]  Rate,
  output logic [11:0] Length,
  output logic        SignalValid,
  output logic        SignalError,
  output logic        FrameDone,
  output logic        Busy
);

  localparam int RUN_W = $clog2(PREAMBLE_BITS + 1);

  plcp_state_t            state, state_next;
  logic [RUN_W-1:0]       run, run_next;
  logic [14:0]            cnt, cnt_next;
  logic [SIGNAL_BITS-2:0] sig, sig_next;
  signal_word_t           word;
  logic                   pay_bit;
  logic                   out_next, ov_next, sv_next, se_next, fd_next, busy_next;
  logic [3:0]             rate_next;
  logic [11:0]            len_next;

  assign word = {sig, Input};

`ifdef DESCRAMBLER_EN
  logic load, step, plain;

  // Seed from the first SERVICE bits, then free-run in step with the transmitter.
  assign load = (state == SERVICE) && (cnt < 15'(LFSR_W));
  assign step = ((state == SERVICE) && !load) || (state == DATA);

  plcp_receiver_descrambler u_descrambler (
    .clk  (Clock),
    .rst  (Reset),
    .load (load),
    .step (step),
    .raw  (Input),
    .plain(plain)
  );

  assign pay_bit = plain;
`else
  assign pay_bit = Input;
`endif

  always_comb begin
    state_next = state;
    run_next   = run;
    cnt_next   = cnt;
    sig_next   = sig;
    rate_next  = Rate;
    len_next   = Length;
    out_next   = 1'b0;
    ov_next    = 1'b0;
    sv_next    = 1'b0;
    se_next    = 1'b0;
    fd_next    = 1'b0;
    case (state)
      HUNT: begin
        // Expected preamble bit is 1 at even run positions, 0 at odd ones.
        if (Input == ~run[0]) begin
          if (run == RUN_W'(PREAMBLE_BITS - 1)) begin
            run_next   = '0;
            state_next = SIGNAL;
          end else begin
            run_next = run + 1'b1;
          end
        end else begin
          run_next = {{(RUN_W-1){1'b0}}, Input};
        end
      end
      SIGNAL: begin
        sig_next = word[SIGNAL_BITS-2:0];
        cnt_next = cnt + 15'd1;
        if (cnt == 15'(SIGNAL_BITS - 1)) begin
          cnt_next = '0;
          if (signal_check(word)) begin
            rate_next  = signal_rate(word);
            len_next   = signal_length(word);
            sv_next    = 1'b1;
            state_next = SERVICE;
          end else begin
            se_next    = 1'b1;
            state_next = HUNT;
          end
        end
      end
      SERVICE: begin
        cnt_next = cnt + 15'd1;
        if (cnt == 15'(SERVICE_BITS - 1)) begin
          cnt_next = '0;
          if (Length == '0) begin
            fd_next    = 1'b1;
            state_next = HUNT;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        out_next = pay_bit;
        ov_next  = 1'b1;
        cnt_next = cnt + 15'd1;
        if (cnt == ({Length, 3'b000} - 15'd1)) begin
          cnt_next   = '0;
          fd_next    = 1'b1;
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
    busy_next = (state_next != HUNT);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= HUNT;
      run         <= '0;
      cnt         <= '0;
      sig         <= '0;
      Output      <= 1'b0;
      OutputValid <= 1'b0;
      Rate        <= 4'h0;
      Length      <= 12'h000;
      SignalValid <= 1'b0;
      SignalError <= 1'b0;
      FrameDone   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state       <= state_next;
      run         <= run_next;
      cnt         <= cnt_next;
      sig         <= sig_next;
      Output      <= out_next;
      OutputValid <= ov_next;
      Rate        <= rate_next;
      Length      <= len_next;
      SignalValid <= sv_next;
      SignalError <= se_next;
      FrameDone   <= fd_next;
      Busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_plcp_receiver.sv
// Directed bench for plcp_receiver: table of frames plus hand-written glitch and reset sequences.
module tb_plcp_receiver;

  logic        Clock;
  logic        Reset;
  logic        Input;
  logic        Output;
  logic        OutputValid;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic        SignalValid;
  logic        SignalError;
  logic        FrameDone;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  logic [6:0] scr;
  localparam logic [6:0] SEED = 7'b1011101;

  typedef struct {
    logic [3:0]  rate;
    logic [11:0] len;
    logic [23:0] flip;
    bit          ok;
    logic [3:0]  exp_rate;
    logic [11:0] exp_len;
  } vec_t;

  vec_t tbl [7];

  plcp_receiver dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Input      (Input),
    .Output     (Output),
    .OutputValid(OutputValid),
    .Rate       (Rate),
    .Length     (Length),
    .SignalValid(SignalValid),
    .SignalError(SignalError),
    .FrameDone  (FrameDone),
    .Busy       (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b);
    Input = b;
    @(posedge Clock);
    #1;
  endtask

  // Transmit-side scrambler model; raw build sends plaintext unchanged.
  task automatic scr_bit(input logic d, output logic o);
    logic fb;
    fb  = scr[6] ^ scr[3];
    scr = {scr[5:0], fb};
`ifdef DESCRAMBLER_EN
    o = d ^ fb;
`else
    o = d;
`endif
  endtask

  function automatic logic pattern(input int i);
    return i[0] ^ i[3] ^ (i % 3 == 0);
  endfunction

  task automatic run_frame(input vec_t v, input int abort_at);
    logic [23:0] sw;
    logic        tx;
    logic        pl;
    int          nbits;
    sw    = {v.rate, 1'b0, v.len, 1'b0, 6'b000000};
    sw[6] = ^sw[23:7];
    sw    = sw ^ v.flip;
    scr   = SEED;
    for (int i = 0; i < 96; i++) begin
      drive(i % 2 == 0);
      check("preamble", {Busy, SignalValid, SignalError, OutputValid, FrameDone},
            (i == 95) ? 5'b10000 : 5'b00000);
    end
    for (int i = 0; i < 24; i++) begin
      drive(sw[23-i]);
      if (i < 23) check("signal_quiet", {SignalValid, SignalError, Busy}, 3'b001);
    end
    check("signal_pulse", {SignalValid, SignalError, Busy}, v.ok ? 3'b101 : 3'b010);
    check("rate", Rate, v.exp_rate);
    check("length", Length, v.exp_len);
    if (v.ok) begin
      for (int i = 0; i < 16; i++) begin
        scr_bit(1'b0, tx);
        drive(tx);
        check("service", {OutputValid, FrameDone, Busy},
              (i == 15 && v.len == 12'h000) ? 3'b010 : 3'b001);
      end
      nbits = int'(v.len) * 8;
      for (int i = 0; i < nbits; i++) begin
        pl = pattern(i);
        scr_bit(pl, tx);
        if (i == abort_at) begin
          Reset = 1'b1;
          #1;
          check("reset_outputs",
                {Output, OutputValid, SignalValid, SignalError, FrameDone, Busy, Rate, Length}, 0);
          Reset = 1'b0;
          return;
        end
        drive(tx);
        check("payload", {OutputValid, Output, FrameDone, Busy},
              {1'b1, pl, i == nbits - 1, i != nbits - 1});
      end
    end
  endtask

  initial begin
    tbl[0] = '{4'hD, 12'h010, 24'h000000, 1'b1, 4'hD, 12'h010};
    tbl[1] = '{4'hD, 12'h010, 24'h000040, 1'b0, 4'hD, 12'h010};
    tbl[2] = '{4'h5, 12'h003, 24'h000000, 1'b1, 4'h5, 12'h003};
    tbl[3] = '{4'hF, 12'h000, 24'h000000, 1'b1, 4'hF, 12'h000};
    tbl[4] = '{4'h3, 12'h001, 24'h080040, 1'b0, 4'hF, 12'h000};
    tbl[5] = '{4'hB, 12'h002, 24'h000001, 1'b0, 4'hF, 12'h000};
    tbl[6] = '{4'h1, 12'h001, 24'h000000, 1'b1, 4'h1, 12'h001};

    Reset = 1'b1;
    Input = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_state",
          {Output, OutputValid, SignalValid, SignalError, FrameDone, Busy, Rate, Length}, 0);
    Reset = 1'b0;

    for (int k = 0; k < 7; k++) run_frame(tbl[k], -1);

    // 50 alternating bits, then a 1 that continues the run; the frame's leading 1 repeats it.
    for (int i = 0; i < 50; i++) begin
      drive(i % 2 == 0);
      check("glitch_hunt", {Busy, SignalValid}, 2'b00);
    end
    drive(1'b1);
    check("glitch_hunt", {Busy, SignalValid}, 2'b00);
    run_frame('{4'h7, 12'h001, 24'h000000, 1'b1, 4'h7, 12'h001}, -1);

    run_frame('{4'h6, 12'h010, 24'h000000, 1'b1, 4'h6, 12'h010}, 40);
    run_frame('{4'h9, 12'h002, 24'h000000, 1'b1, 4'h9, 12'h002}, -1);

    drive(1'b0);
    check("idle_after", {OutputValid, SignalValid, SignalError, FrameDone, Busy}, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plcp_receiver.md
# plcp_receiver

Bit-serial 802.11a PLCP frame receiver, the receive-side counterpart of the Transmitter. Hunts for the alternating PLCP preamble, captures and checks the SIGNAL field (RATE, reserved, LENGTH, parity, tail), consumes the SERVICE field, then delivers LENGTH octets of payload as a serial bit stream. Sits between the bit-level front end and the MAC-side deframer.

## Interface
- PREAMBLE_BITS, 96: consecutive alternating bits (starting with 1) that constitute a valid preamble
- SERVICE_BITS, 16: SERVICE field length in bits
- Clock  input  1  rising-edge clock; one serial bit per cycle
- Reset  input  1  asynchronous, active-high reset
- Input  input  1  received serial bit, sampled every rising edge
- Output  output  1  payload bit (descrambled when DESCRAMBLER_EN)
- OutputValid  output  1  Output carries a payload bit this cycle
- Rate  output  4  captured RATE, first received bit in Rate[3]; held until next SIGNAL
- Length  output  12  captured LENGTH in octets, first received bit in Length[11]; held until next SIGNAL
- SignalValid  output  1  one-cycle pulse: SIGNAL passed all checks
- SignalError  output  1  one-cycle pulse: SIGNAL failed a check
- FrameDone  output  1  one-cycle pulse coincident with last payload OutputValid
- Busy  output  1  high in SIGNAL, SERVICE and DATA states

## Operation
- States: HUNT, SIGNAL, SERVICE, DATA.
- HUNT: run counter of alternating bits. Bit 1 after 0 (or count 0 with bit 1) increments; a non-alternating bit resets count to 1 if the bit is 1, else 0. When count reaches PREAMBLE_BITS, next cycle enters SIGNAL with count cleared.
- SIGNAL: shift 24 bits: RATE(4), reserved(1), LENGTH(12), parity(1), tail(6). After 24th bit check: reserved == 0; XOR of the 18 RATE/reserved/LENGTH/parity bits == 0 (even parity); all tail bits 0.
  - Pass: load Rate/Length, pulse SignalValid, go SERVICE.
  - Fail: pulse SignalError, Rate/Length unchanged, go HUNT.
- SERVICE: consume SERVICE_BITS bits, no output. With DESCRAMBLER_EN the first 7 SERVICE bits are shifted into the descrambler state (scrambled zeros reveal the LFSR state). Then: Length == 0 → pulse FrameDone (OutputValid stays low), go HUNT; else go DATA.
- DATA: 15-bit bit counter, target Length*8 (max 32760). Each received bit presented on Output with OutputValid. After bit Length*8: FrameDone pulses with that bit, go HUNT.
- Input contents are not examined outside the current state: alternating patterns in DATA do not restart HUNT.
- Reset (any time, including mid-frame): state HUNT, all counters 0, Output/OutputValid/SignalValid/SignalError/FrameDone/Busy 0, Rate 4'h0, Length 12'h000, descrambler state 0.

## Timing
- All outputs registered.
- Latency 1 cycle: bit sampled at edge n appears on Output/OutputValid after edge n.
- SignalValid/SignalError assert after the edge sampling the 24th SIGNAL bit; Rate/Length update on that same edge.
- First payload bit is sampled on the edge after the last SERVICE bit; payload is gapless, one bit per cycle.
- Preamble-to-first-OutputValid: PREAMBLE_BITS + 24 + SERVICE_BITS + 1 cycles after the first preamble bit edge.
- A new preamble is recognised starting the cycle after FrameDone/SignalError.

## Configuration
- DESCRAMBLER_EN defined: payload bits pass through the x^7+x^4+1 additive descrambler (out = in XOR s[6] XOR s[3]; state shifts in s[6] XOR s[3]), seeded in SERVICE; still 1-cycle latency.
- Undefined: no descrambler instantiated; Output = raw Input; SERVICE is still consumed.

## Structure
- Package plcp_pkg: state encoding, PREAMBLE_BITS/SERVICE_BITS defaults, SIGNAL_BITS = 24, field offsets (RATE 0-3, reserved 4, LENGTH 5-16, parity 17, tail 18-23). Shared with Transmitter.
- Sub-module Descrambler (7-bit LFSR, load/shift/enable), instantiated only under DESCRAMBLER_EN.

## Test plan
- 96 alternating bits, SIGNAL 1101 0 000000010000 0 000000, 16 SERVICE zeros, 128 payload bits → SignalValid with Rate 4'hD, Length 12'h010; 128 OutputValid cycles matching payload (raw build); FrameDone on the 128th.
- Same frame with parity bit flipped to 1 → SignalError pulse, no OutputValid; immediately following correct frame is received.
- 50 alternating bits, a repeated 1, then a full frame → lock only on the full 96-bit run; single SignalValid.
- LENGTH 0 frame → SignalValid, FrameDone after SERVICE, OutputValid never asserted.
- Reset asserted at payload bit 40 → all outputs 0 asynchronously; next frame received normally.
- DESCRAMBLER_EN build, frame scrambled with seed 7'b1011101 → recovered payload equals original plaintext.
